// File: rtl/controle_busca.sv
// controle_busca: instruction-fetch controller with PC, branch redirect and shared loader write port
// Clock/Reset            : clock, async active-high reset
// Run/Redirect/Redirect_pc: fetch enable, PC redirect with flush
// Load_*                 : program-loader write request/accept
// Instr/Instr_pc/Instr_valid/Instr_ready: fetched word handshake to decode
// Mem_*                  : single-port synchronous instruction memory
module controle_busca #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_pc,
  input  logic              Load_valid,
  input  logic [ADDR_W-1:0] Load_addr,
  input  logic [DATA_W-1:0] Load_data,
  output logic              Load_ready,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_pc,
  output logic              Instr_valid,
  input  logic              Instr_ready,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Wren,
  output logic [DATA_W-1:0] Mem_Din,
  input  logic [DATA_W-1:0] Mem_Q
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_pc, w_pc, r_instr_pc, w_instr_pc;
  logic [DATA_W-1:0]   r_instr, w_instr;
  logic                r_valid, w_valid;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
      r_valid    <= w_valid;
    end
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    w_valid    = r_valid;
    if (Redirect) begin
      w_state = IDLE;
      w_pc    = Redirect_pc;
      w_valid = 1'b0;
    end else
      case (r_state)
        IDLE:  w_state = (Run && !Load_valid) ? FETCH : IDLE;
        FETCH: begin
          w_instr    = Mem_Q;
          w_instr_pc = r_pc;
          w_valid    = 1'b1;
          w_pc       = r_pc + 1'b1;
          w_state    = HOLD;
        end
        HOLD: if (Instr_ready) begin
          w_valid = 1'b0;
          w_state = Run ? FETCH : IDLE;
        end
        default: w_state = IDLE;
      endcase
  end
  assign Load_ready  = Reset | (r_state == IDLE && !Redirect);
  assign Mem_Wren    = Load_valid & Load_ready & ~Reset;
  assign Mem_Address = Mem_Wren ? Load_addr : r_pc;
  assign Mem_Din     = Load_data;
  assign Instr       = r_instr;
  assign Instr_pc    = r_instr_pc;
  assign Instr_valid = r_valid;
endmodule

// File: tb/tb_controle_busca.sv
// tb_controle_busca: directed plan steps plus randomized traffic against a transaction-level model
module tb_controle_busca;
  logic        Clock = 1'b0;
  logic        Reset, Run, Redirect, Load_valid, Instr_ready;
  logic [3:0]  Redirect_pc, Load_addr;
  logic [15:0] Load_data;
  logic        Load_ready, Instr_valid, Mem_Wren;
  logic [15:0] Instr, Mem_Din, Mem_Q;
  logic [3:0]  Instr_pc, Mem_Address;
  logic [15:0] mem [16];
  logic [15:0] mm [16];
  logic [3:0]  m_next;
  int          checks = 0, errors = 0, n_hs = 0;

  controle_busca dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Redirect(Redirect), .Redirect_pc(Redirect_pc),
    .Load_valid(Load_valid), .Load_addr(Load_addr), .Load_data(Load_data), .Load_ready(Load_ready),
    .Instr(Instr), .Instr_pc(Instr_pc), .Instr_valid(Instr_valid), .Instr_ready(Instr_ready),
    .Mem_Address(Mem_Address), .Mem_Wren(Mem_Wren), .Mem_Din(Mem_Din), .Mem_Q(Mem_Q)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock)
    if (Mem_Wren) begin
      mem[Mem_Address] <= Mem_Din;
      Mem_Q <= Mem_Din;
    end else
      Mem_Q <= mem[Mem_Address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins, input logic [3:0] pc);
    chk({tag, "_valid"}, Instr_valid, v);
    chk({tag, "_instr"}, Instr, ins);
    chk({tag, "_pc"}, Instr_pc, pc);
  endtask

  initial begin
    logic [15:0] exp_w [3];
    logic [3:0]  exp_p [3];
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0298;
    mem[1] = 16'h1298;
    Reset = 1; Run = 0; Redirect = 0; Redirect_pc = 0;
    Load_valid = 1; Load_addr = 0; Load_data = 0; Instr_ready = 0;
    #2;
    chk_out("rst", 0, 16'h0, 4'h0);
    chk("rst_wren", Mem_Wren, 0);
    chk("rst_lrdy", Load_ready, 1);
    // power-on fetch
    @(posedge Clock); #1;
    Reset = 0; Load_valid = 0; Run = 1; Instr_ready = 1;
    #1;
    chk("idle_lrdy", Load_ready, 1);
    chk("idle_addr", Mem_Address, 0);
    tick; chk("c1_valid", Instr_valid, 0); chk("fetch_lrdy", Load_ready, 0);
    tick; chk_out("c2", 1, 16'h0298, 4'h0);
    tick; chk("c3_valid", Instr_valid, 0);
    tick; chk_out("c4", 1, 16'h1298, 4'h1);
    // backpressure
    Instr_ready = 0;
    repeat (5) begin tick; chk_out("bp", 1, 16'h1298, 4'h1); end
    Instr_ready = 1;
    tick; chk("bp_rel_valid", Instr_valid, 0);
    tick; chk_out("bp_next", 1, 16'h0000, 4'h2);
    // loader
    Run = 0;
    tick; chk("ld_idle_valid", Instr_valid, 0); chk("ld_idle_addr", Mem_Address, 3);
    Load_valid = 1; Load_addr = 2; Load_data = 16'hABCD;
    #1;
    chk("ld_lrdy", Load_ready, 1); chk("ld_wren", Mem_Wren, 1); chk("ld_addr", Mem_Address, 2);
    tick;
    Redirect = 1; Redirect_pc = 2;
    #1;
    chk("rd_lrdy", Load_ready, 0); chk("rd_wren", Mem_Wren, 0);
    tick;
    Redirect = 0; Load_valid = 0; Run = 1;
    tick; chk("ld_fetch_valid", Instr_valid, 0);
    tick; chk_out("ld_word", 1, 16'hABCD, 4'h2);
    Instr_ready = 0; Load_valid = 1; Load_addr = 5;
    #1;
    chk("hold_lrdy", Load_ready, 0); chk("hold_wren", Mem_Wren, 0);
    Load_valid = 0;
    // redirect with wrap
    Instr_ready = 1; Redirect = 1; Redirect_pc = 14;
    tick; Redirect = 0; chk("rw_v1", Instr_valid, 0);
    tick; chk("rw_v2", Instr_valid, 0);
    tick; chk_out("rw14", 1, 16'h0, 4'he);
    exp_p[0] = 4'hf; exp_p[1] = 4'h0; exp_p[2] = 4'h1;
    exp_w[0] = 16'h0; exp_w[1] = 16'h0298; exp_w[2] = 16'h1298;
    for (int i = 0; i < 3; i++) begin
      tick; tick; chk_out("rw_seq", 1, exp_w[i], exp_p[i]);
    end
    // async reset mid-HOLD
    Instr_ready = 0;
    #2; Reset = 1; Load_valid = 1;
    #1;
    chk_out("areset", 0, 16'h0, 4'h0);
    chk("areset_lrdy", Load_ready, 1); chk("areset_wren", Mem_Wren, 0);
    @(posedge Clock); #1;
    Reset = 0; Load_valid = 0; Instr_ready = 1; Run = 1;
    tick; chk("ar_fetch_valid", Instr_valid, 0);
    tick; chk_out("ar_first", 1, 16'h0298, 4'h0);
    // run drop
    tick; tick; chk_out("rd_pc1", 1, 16'h1298, 4'h1);
    tick; tick; chk_out("rd_pc2", 1, 16'hABCD, 4'h2);
    Run = 0;
    tick; chk("drop_valid", Instr_valid, 0); chk("drop_addr", Mem_Address, 3); chk("drop_wren", Mem_Wren, 0);
    tick; chk("drop_stay", Instr_valid, 0);
    Run = 1;
    tick; tick; chk_out("drop_resume", 1, 16'h0, 4'h3);
    // randomized traffic: every accepted word must follow the model's PC stream and memory image
    for (int i = 0; i < 16; i++) mm[i] = 16'h0000;
    mm[0] = 16'h0298; mm[1] = 16'h1298; mm[2] = 16'hABCD;
    m_next = 4'h3;
    for (int c = 0; c < 3000; c++) begin
      Run         = ($urandom_range(0, 3) != 0);
      Instr_ready = ($urandom_range(0, 4) < 3);
      Redirect    = ($urandom_range(0, 15) == 0);
      Redirect_pc = 4'($urandom);
      Load_valid  = ($urandom_range(0, 3) == 0);
      Load_addr   = 4'($urandom);
      Load_data   = 16'($urandom);
      #1;
      chk("r_wren", Mem_Wren, Load_valid & Load_ready);
      chk("r_addr", Mem_Address, Mem_Wren ? Load_addr : Mem_Address);
      if (Load_ready) chk("r_lrdy_excl", Instr_valid | Redirect, 0);
      if (Instr_valid && Instr_ready) begin
        chk("r_pc", Instr_pc, m_next);
        chk("r_word", Instr, mm[m_next]);
        m_next = m_next + 4'h1;
        n_hs++;
      end
      if (Load_valid && Load_ready) mm[Load_addr] = Load_data;
      if (Redirect) m_next = Redirect_pc;
      tick;
    end
    chk("r_progress", n_hs > 200, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
